comparator_seq: RTL and testbench

Multi-cycle, parametrised magnitude comparator. It is the sequential successor to the 4-bit combinational comparator.
- Compares two WIDTH-bit operands one CHUNK-bit slice per clock, most significant slice first.
- Stops early at the first slice that differs.
- Supports unsigned and two's-complement signed compare.
- Sits in the datapath next to the ALU. Controllers start it with a start/done handshake and read the registered gto/lto/eqo flags.

---
 rtl/comparator_seq_pkg.sv | 18 +
 rtl/comparator_slice.sv | 33 +++
 rtl/comparator_seq.sv | 123 ++++++++++++
 tb/tb_comparator_seq.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/comparator_seq_pkg.sv
// Shared definitions for the sequential magnitude comparator.
// Holds the FSM state encoding and the bit positions controllers use when
// they pack done/gt/lt/eq into a status word.
package comparator_seq_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_CMP  = 1'b1
  } state_t;

  // Status-word bit positions: {done, gt, lt, eq}
  localparam int FLAG_EQ_BIT   = 0;
  localparam int FLAG_LT_BIT   = 1;
  localparam int FLAG_GT_BIT   = 2;
  localparam int FLAG_DONE_BIT = 3;
  localparam int FLAG_W        = 4;

endpackage : comparator_seq_pkg

// File: rtl/comparator_slice.sv
// Purpose: combinational magnitude compare of one CHUNK-bit slice.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; outputs follow inputs.
// Ports: a, b = slice operands; invert_msb = flip both MSBs before comparing
//        (turns a two's-complement top slice into an unsigned compare);
//        gt/lt/eq = a>b, a<b, a==b after the optional MSB flip.
module comparator_slice #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             invert_msb,
  output logic             gt,
  output logic             lt,
  output logic             eq
);

  logic [CHUNK-1:0] a_m;
  logic [CHUNK-1:0] b_m;

  // Flipping the sign bit of both operands maps signed order onto unsigned order.
  always_comb begin
    a_m            = a;
    b_m            = b;
    a_m[CHUNK-1]   = a[CHUNK-1] ^ invert_msb;
    b_m[CHUNK-1]   = b[CHUNK-1] ^ invert_msb;
  end

  assign gt = (a_m > b_m);
  assign lt = (a_m < b_m);
  assign eq = (a_m == b_m);

endmodule : comparator_slice

// File: rtl/comparator_seq.sv
// Purpose: multi-cycle WIDTH-bit magnitude compare, CHUNK bits per cycle, MSB slice first, early exit.
// Latency: done/flags update k+1 edges after start is accepted (k = first differing slice), 1..NCHUNK.
// Backpressure: start is ignored while busy=1; accepted again in the done cycle (no bubble).
// Ports: clk, rst_n (async active-low); start/signed_mode/num1/num2 sampled on acceptance;
//        busy = compare in progress; done = one-cycle result pulse; gto/lto/eqo = registered A>B, A<B, A==B.
module comparator_seq
  import comparator_seq_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] num1,
  input  logic [WIDTH-1:0] num2,
  output logic             busy,
  output logic             done,
  output logic             gto,
  output logic             lto,
  output logic             eqo
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NCHUNK - 1);

  state_t            state, state_d;
  logic [IDXW-1:0]   idx, idx_d;
  logic [WIDTH-1:0]  opa, opb;
  logic              smode;
  logic              accept;
  logic              done_d, gt_d, lt_d, eq_d;

  logic [CHUNK-1:0]  sl_a, sl_b;
  logic              sl_gt, sl_lt, sl_eq;

  // Current slice, counted from the top of the latched operands.
  always_comb begin
    sl_a = opa[(WIDTH-1) - CHUNK*int'(idx) -: CHUNK];
    sl_b = opb[(WIDTH-1) - CHUNK*int'(idx) -: CHUNK];
  end

  // Only the top slice carries the sign bit.
  comparator_slice #(
    .CHUNK (CHUNK)
  ) u_slice (
    .a          (sl_a),
    .b          (sl_b),
    .invert_msb (smode && (idx == '0)),
    .gt         (sl_gt),
    .lt         (sl_lt),
    .eq         (sl_eq)
  );

  // Next-state and result logic
  always_comb begin
    state_d = state;
    idx_d   = idx;
    accept  = 1'b0;
    done_d  = 1'b0;
    gt_d    = gto;
    lt_d    = lto;
    eq_d    = eqo;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept  = 1'b1;
          idx_d   = '0;
          state_d = ST_CMP;
        end
      end
      ST_CMP: begin
        if (!sl_eq) begin
          gt_d    = sl_gt;
          lt_d    = sl_lt;
          eq_d    = 1'b0;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else if (idx == IDX_LAST) begin
          gt_d    = 1'b0;
          lt_d    = 1'b0;
          eq_d    = 1'b1;
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          idx_d   = idx + IDXW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      idx   <= '0;
      opa   <= '0;
      opb   <= '0;
      smode <= 1'b0;
      done  <= 1'b0;
      gto   <= 1'b0;
      lto   <= 1'b0;
      eqo   <= 1'b0;
    end else begin
      state <= state_d;
      idx   <= idx_d;
      done  <= done_d;
      gto   <= gt_d;
      lto   <= lt_d;
      eqo   <= eq_d;
      if (accept) begin
        opa   <= num1;
        opb   <= num2;
        smode <= signed_mode;
      end
    end
  end

  assign busy = (state == ST_CMP);

endmodule : comparator_seq

// File: tb/tb_comparator_seq.sv
// Directed + randomized bench for comparator_seq (WIDTH=16, CHUNK=4).
// Expected flags and latency come from an arithmetic reference model.
module tb_comparator_seq;

  localparam int WIDTH  = 16;
  localparam int CHUNK  = 4;
  localparam int NCHUNK = WIDTH / CHUNK;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             start = 1'b0;
  logic             signed_mode = 1'b0;
  logic [WIDTH-1:0] num1 = '0;
  logic [WIDTH-1:0] num2 = '0;
  logic             busy, done, gto, lto, eqo;

  int errors = 0;
  int checks = 0;
  logic [2:0] prev_fl = 3'b000;   // {gt, lt, eq} of the last completed compare

  comparator_seq #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .signed_mode (signed_mode),
    .num1        (num1),
    .num2        (num2),
    .busy        (busy),
    .done        (done),
    .gto         (gto),
    .lto         (lto),
    .eqo         (eqo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain signed/unsigned arithmetic for the flags, first
  // differing slice from the top for the latency.
  function automatic void model(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                                input logic s, output logic [2:0] fl, output int lat);
    int  ua, ub, sh, mask;
    bit  found;
    if (s) begin
      if ($signed(a) > $signed(b))      fl = 3'b100;
      else if ($signed(a) < $signed(b)) fl = 3'b010;
      else                              fl = 3'b001;
    end else begin
      if (a > b)      fl = 3'b100;
      else if (a < b) fl = 3'b010;
      else            fl = 3'b001;
    end
    ua = int'(a);
    ub = int'(b);
    mask = (1 << CHUNK) - 1;
    lat = NCHUNK;
    found = 1'b0;
    for (int k = 0; k < NCHUNK; k++) begin
      sh = WIDTH - CHUNK * (k + 1);
      if (!found && (((ua >> sh) & mask) != ((ub >> sh) & mask))) begin
        lat = k + 1;
        found = 1'b1;
      end
    end
  endfunction

  // Called at a point #1 after a rising edge with the DUT idle (or in its done cycle).
  // Returns #1 after the edge that raised done.
  task automatic run_cmp(input string tag, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                         input logic s, input bit disturb);
    logic [2:0] efl;
    int         elat;
    int         lat;
    bit         seen;
    model(a, b, s, efl, elat);
    num1 = a;
    num2 = b;
    signed_mode = s;
    start = 1'b1;
    @(posedge clk); #1;
    if (disturb) begin
      // keep start high and scramble inputs while busy: must be ignored
      num1 = ~a;
      num2 = ~b;
      signed_mode = ~s;
    end else begin
      start = 1'b0;
    end
    check({tag, "_busy_acc"}, busy, 1);
    check({tag, "_done_low"}, done, 0);
    check({tag, "_flags_hold"}, {gto, lto, eqo}, prev_fl);
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 3 * NCHUNK) begin
      @(posedge clk); #1;
      lat++;
      if (lat == 1) start = 1'b0;
      if (done) seen = 1'b1;
      else if (busy !== 1'b1) check({tag, "_busy_mid"}, busy, 1);
    end
    check({tag, "_done_seen"}, done, 1);
    check({tag, "_latency"}, lat, elat);
    check({tag, "_flags"}, {gto, lto, eqo}, efl);
    check({tag, "_busy_done"}, busy, 0);
    prev_fl = efl;
  endtask

  task automatic idle(input string tag, input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      check({tag, "_idle_done"}, done, 0);
      check({tag, "_idle_flags"}, {gto, lto, eqo}, prev_fl);
    end
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rs;

    // 1. reset, then equal operands
    #2 rst_n = 1'b0;
    #1 check("reset_outputs", {busy, done, gto, lto, eqo}, 5'b0);
    @(posedge clk); @(posedge clk); #1;
    check("reset_hold", {busy, done, gto, lto, eqo}, 5'b0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_cmp("eq_1234", 16'h1234, 16'h1234, 1'b0, 1'b0);
    idle("eq_1234", 1);

    // 2. top-slice early exit, unsigned then signed
    run_cmp("top_uns", 16'h8000, 16'h7FFF, 1'b0, 1'b0);
    idle("top_uns", 1);
    run_cmp("top_sgn", 16'h8000, 16'h7FFF, 1'b1, 1'b0);
    idle("top_sgn", 1);

    // 3. late decisions
    run_cmp("late_gt", 16'h1235, 16'h1234, 1'b0, 1'b0);
    run_cmp("late_lt", 16'h1204, 16'h1234, 1'b0, 1'b0);
    idle("late_lt", 2);

    // 4. start/operand changes while busy are ignored; back-to-back start
    run_cmp("ignore", 16'h1235, 16'h1234, 1'b0, 1'b1);
    run_cmp("b2b", 16'h0001, 16'hFFFF, 1'b0, 1'b0);
    idle("b2b", 2);

    // 5. reset mid-compare
    num1 = 16'h1234; num2 = 16'h1234; signed_mode = 1'b0; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    @(posedge clk); @(posedge clk); #2;
    rst_n = 1'b0;
    #1 check("midrst_outputs", {busy, done, gto, lto, eqo}, 5'b0);
    prev_fl = 3'b000;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("midrst_no_done", done, 0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    check("midrst_after", {busy, done, gto, lto, eqo}, 5'b0);
    run_cmp("post_rst", 16'h00A0, 16'h00A0, 1'b0, 1'b0);
    idle("post_rst", 1);

    // 6. signed negatives
    run_cmp("neg_pair", 16'hFFFE, 16'hFFFF, 1'b1, 1'b0);
    run_cmp("neg_pos", 16'hF000, 16'h0FFF, 1'b1, 1'b0);
    idle("neg_pos", 1);

    // randomized compares, biased toward shared upper slices
    for (int n = 0; n < 40; n++) begin
      ra = WIDTH'($urandom);
      rs = 1'($urandom);
      case ($urandom_range(2))
        0:       rb = ra;
        1:       rb = ra ^ (WIDTH'(1) << $urandom_range(WIDTH - 1));
        default: rb = WIDTH'($urandom);
      endcase
      run_cmp("rand", ra, rb, rs, 1'($urandom_range(3) == 0) && 1'b0);
      if ($urandom_range(1) == 1) idle("rand", 1);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule : tb_comparator_seq
